rr_arb_mux_4_1: RTL



---
 rtl/rr_arb_mux_4_1.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rr_arb_mux_4_1.sv
// Purpose : registered 4:1 round-robin arbitrated mux; picks one requesting
//           channel per cycle into a single-entry output register.
// Latency : 1 cycle from input acceptance to out_valid/out_data/out_sel.
// Backpr. : out_ready=0 while FULL drops every in_ready; pop+push in one edge
//           sustains 1 word/cycle.
// Ports   : clk, rst_n (async active-low); in_valid[3:0], d0..d3[W-1:0] in,
//           in_ready[3:0] out; out_valid, out_data[W-1:0], out_sel[1:0] out,
//           out_ready in.
// Config  : define RR_ARB_MUX_FIXED_PRIO_EN for fixed priority (channel 0
//           highest, no rotating pointer); default build is round-robin.
module rr_arb_mux_4_1 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_data;
  logic [1:0]   r_sel;
  logic         w_load;
  logic         w_hit;
  logic         w_xfer;
  logic [1:0]   w_idx;
  logic [1:0]   w_gidx;
  logic [3:0]   w_grant;
  logic [W-1:0] w_mux;

`ifndef RR_ARB_MUX_FIXED_PRIO_EN
  logic [1:0]   r_ptr;
`endif

  // Arbitration, handshake and next state.
  always_comb begin
    w_load      = (r_state == S_EMPTY) || out_ready;
    w_hit       = 1'b0;
    w_idx       = 2'd0;
    w_gidx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
      w_idx = 2'(k);
`else
      // 2-bit add wraps naturally, giving ptr, ptr+1, ptr+2, ptr+3 mod 4.
      w_idx = r_ptr + 2'(k);
`endif
      if (!w_hit && in_valid[w_idx]) begin
        w_hit  = 1'b1;
        w_gidx = w_idx;
      end
    end
    w_grant  = w_hit ? (4'b0001 << w_gidx) : 4'b0000;
    // Gated by rst_n so nothing is accepted while reset is held.
    in_ready = (w_load && rst_n) ? w_grant : 4'b0000;
    w_xfer   = |in_ready;

    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = S_FULL;
    end else if ((r_state == S_FULL) && out_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  // Index comes only from in_valid/ptr, so an ungranted channel never
  // steers its data (or X) into the register.
  always_comb begin
    w_mux = '0;
    case (w_gidx)
      2'd0:    w_mux = d0;
      2'd1:    w_mux = d1;
      2'd2:    w_mux = d2;
      default: w_mux = d3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sel  <= 2'd0;
    end else if (w_xfer) begin
      r_data <= w_mux;
      r_sel  <= w_gidx;
    end
  end

`ifndef RR_ARB_MUX_FIXED_PRIO_EN
  // Priority moves only on a transfer; idle or stalled cycles leave it put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd0;
    end else if (w_xfer) begin
      r_ptr <= w_gidx + 2'd1;
    end
  end
`endif

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
